xpb_reduce_accum: RTL and testbench
===================================

# xpb_reduce_accum

Sequencing accumulator for the xpb-based modular reduction path. It splits the upper word of a product into 5-bit segments and drives each segment, one per cycle, into the external registered xpb lookup-table bank. It sums the returned 1024-bit constants with the lower word of the product and emits a widened, not-yet-fully-reduced result. It sits between the multiplier/squarer output and the final carry-propagate/compare stage, and directly feeds the xpb tables.

## Interface
- WIDTH, 1024, lower-word and xpb constant width
- IDX_BITS, 5, bits per segment (table index width)
- NUM_SEG, 8, number of upper-word segments
- SEG_W, $clog2(NUM_SEG), lut_seg width (derived)
- ACC_W, WIDTH+$clog2(NUM_SEG+1), accumulator/result width (derived; 1028 at defaults)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand available
- in_ready  out  1  block idle, can accept
- in_lower  in  WIDTH  lower product word
- in_upper  in  NUM_SEG*IDX_BITS  upper product word; segment k = in_upper[k*IDX_BITS +: IDX_BITS]
- lut_seg  out  SEG_W  table select (segment number)
- lut_idx  out  IDX_BITS  table index
- lut_data  in  WIDTH  table output; registered, valid one cycle after lut_seg/lut_idx
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  ACC_W  in_lower + Σ table[k][seg_k]

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at an edge, capture in_upper, load acc <= zero-extended in_lower, set cnt=0, go to ISSUE.
- ISSUE: drive lut_seg=cnt, lut_idx=segment cnt from registers. Each edge increments cnt. When cnt reaches 1, start accumulating acc <= acc + lut_data. After issuing cnt=NUM_SEG-1, go to DRAIN.
- DRAIN: one cycle; add the final lut_data, then go to DONE.
- DONE: out_valid=1 and out_data=acc, both held stable until out_valid&out_ready, then go to IDLE.
- Every segment is issued and added, including index 0. The table returns 0 for index 0, so nothing is skipped.
- Arithmetic is unsigned at ACC_W bits. The maximum sum (NUM_SEG+1)·(2^WIDTH−1) fits, so there is never overflow or wrap.
- in_ready=0 in ISSUE, DRAIN and DONE. in_valid is ignored outside IDLE. There is no operand overlap.
- lut_seg and lut_idx hold 0 in IDLE, DRAIN and DONE.

## Timing
- Reset (async assert, sync deassert in the clk domain) gives: state=IDLE, in_ready=1, out_valid=0, out_data=0, lut_seg=0, lut_idx=0, cnt=0, acc=0.
- Accept edge T: index k is presented in cycle T+1+k, and lut_data for k arrives in cycle T+2+k.
- out_valid rises in cycle T+NUM_SEG+2, which is 10 cycles at defaults.
- The output handshake on edge E returns in_ready=1 in cycle E+1. Minimum initiation interval is NUM_SEG+3 cycles.
- rst_n asserted mid-operation aborts immediately to reset values. A partial result is never emitted.
- Backpressure: out_ready low holds DONE indefinitely with out_data unchanged.

## Structure
- Shared package holds: WIDTH, IDX_BITS, NUM_SEG, the derived SEG_W and ACC_W, and the state enum. The xpb table bank uses the same constants.
- Sub-module xpb_accum_ctrl holds the FSM and segment counter, and generates lut_seg/lut_idx and the accumulate-enable.
- The top level holds the operand registers and the ACC_W adder.
- The xpb table bank stays external.

## Test plan
- Zero upper word: in_upper=0, in_lower=0x1234, real zero-entry tables. Required: out_data=0x1234, out_valid in cycle T+10.
- Index/select ordering: bench stub returns lut_data = seg*32+idx with 1-cycle latency, in_upper all 5'h1F, in_lower=0. Required: out_data=0x478 (1144), and the lut_seg sequence is 0..7 in cycles T+1..T+8.
- Maximum carry: stub returns 2^1024−1 for any nonzero idx, in_upper all 5'h1F, in_lower=2^1024−1. Required: out_data=9·2^1024−9, with top nibble 0x8 and low word 0xFFF…F7.
- Backpressure: out_ready low for 5 cycles after out_valid, in_valid held high. Required: out_data stable, in_ready=0, no second capture. Handshake on the 6th cycle, then in_ready=1 the next cycle.
- Back-to-back: in_valid and out_ready held high for 3 operands. Required: 3 correct results spaced 11 cycles apart.
- Reset mid-ISSUE: drop rst_n at T+4. Required: immediately in_ready=1, out_valid=0, lut_idx=0. A fresh operand after release yields only its own correct sum.

Source files
------------

// File: rtl/xpb_reduce_accum_pkg.sv
// Shared constants and state type for the xpb reduction accumulator and its table bank.
package xpb_reduce_accum_pkg;

  localparam int unsigned WIDTH    = 1024;
  localparam int unsigned IDX_BITS = 5;
  localparam int unsigned NUM_SEG  = 8;
  localparam int unsigned SEG_W    = $clog2(NUM_SEG);
  localparam int unsigned ACC_W    = WIDTH + $clog2(NUM_SEG + 1);
  localparam int unsigned UPPER_W  = NUM_SEG * IDX_BITS;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/xpb_accum_ctrl.sv
// Sequencer: walks the upper-word segments into the xpb table bank and times the accumulate.
module xpb_accum_ctrl
  import xpb_reduce_accum_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  input  logic                out_ready_i,
  input  logic [UPPER_W-1:0]  upper_i,
  output logic                in_ready_o,
  output logic                out_valid_o,
  output logic                load_o,
  output logic                acc_en_o,
  output logic [SEG_W-1:0]    lut_seg_o,
  output logic [IDX_BITS-1:0] lut_idx_o
);

  state_e           state_q;
  logic [SEG_W-1:0] cnt_q;
  logic             issue;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            state_q <= StIssue;
            cnt_q   <= '0;
          end
        end
        StIssue: begin
          if (cnt_q == SEG_W'(NUM_SEG - 1)) begin
            state_q <= StDrain;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrain: state_q <= StDone;
        StDone: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign issue       = (state_q == StIssue);
  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign load_o      = in_ready_o & in_valid_i;
  // Table data lags the index by one cycle, so the first add lands when cnt is 1.
  assign acc_en_o    = (issue && (cnt_q != '0)) || (state_q == StDrain);
  assign lut_seg_o   = issue ? cnt_q : '0;
  assign lut_idx_o   = issue ? upper_i[32'(cnt_q) * IDX_BITS +: IDX_BITS] : '0;

endmodule

// File: rtl/xpb_reduce_accum.sv
// Top: operand capture and widened accumulator summing the lower word with xpb constants.
module xpb_reduce_accum
  import xpb_reduce_accum_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    in_lower_i,
  input  logic [UPPER_W-1:0]  in_upper_i,
  output logic [SEG_W-1:0]    lut_seg_o,
  output logic [IDX_BITS-1:0] lut_idx_o,
  input  logic [WIDTH-1:0]    lut_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_W-1:0]    out_data_o
);

  logic [UPPER_W-1:0] upper_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               load, acc_en;

  xpb_accum_ctrl u_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .out_ready_i (out_ready_i),
    .upper_i     (upper_q),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .load_o      (load),
    .acc_en_o    (acc_en),
    .lut_seg_o   (lut_seg_o),
    .lut_idx_o   (lut_idx_o)
  );

  // ACC_W leaves headroom for NUM_SEG+1 full-width terms, so no wrap is possible.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = ACC_W'(in_lower_i);
    end else if (acc_en) begin
      acc_d = acc_q + ACC_W'(lut_data_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      upper_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (load) upper_q <= in_upper_i;
    end
  end

  assign out_data_o = acc_q;

endmodule

// File: tb/tb_xpb_reduce_accum.sv
// Directed bench for xpb_reduce_accum with a one-cycle-latency table stub.
module tb_xpb_reduce_accum;
  import xpb_reduce_accum_pkg::*;

  logic                clk, rst_n;
  logic                in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0]    in_lower;
  logic [UPPER_W-1:0]  in_upper;
  logic [SEG_W-1:0]    lut_seg;
  logic [IDX_BITS-1:0] lut_idx;
  logic [WIDTH-1:0]    lut_data;
  logic [ACC_W-1:0]    out_data;
  logic [1:0]          mode;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  localparam logic [UPPER_W-1:0] UpAllMax = 40'hFF_FFFF_FFFF;
  localparam logic [UPPER_W-1:0] UpAllOne = 40'h08_4210_8421;
  localparam logic [UPPER_W-1:0] UpRamp   =
    {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

  xpb_reduce_accum dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_lower_i  (in_lower),
    .in_upper_i  (in_upper),
    .lut_seg_o   (lut_seg),
    .lut_idx_o   (lut_idx),
    .lut_data_i  (lut_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Table stub: mode 0 all-zero, mode 1 seg*32+idx, mode 2 all-ones for nonzero idx.
  always @(posedge clk) begin
    case (mode)
      2'd1:    lut_data <= WIDTH'({lut_seg, lut_idx});
      2'd2:    lut_data <= (lut_idx != '0) ? {WIDTH{1'b1}} : '0;
      default: lut_data <= '0;
    endcase
  end

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", tag,
             obs[ACC_W-1:WIDTH], obs[63:0], exp[ACC_W-1:WIDTH], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand and wait for out_valid; optionally check the issue sequence.
  task automatic run_op(input logic [UPPER_W-1:0] up, input logic [WIDTH-1:0] lo,
                        input logic [ACC_W-1:0] exp, input bit chk_seq, input string tag);
    int n;
    in_upper = up;
    in_lower = lo;
    in_valid = 1'b1;
    chk({tag, "_ready"}, ACC_W'(in_ready), ACC_W'(1));
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 30) begin
      if (chk_seq && n <= 8) begin
        chk({tag, "_seg"}, ACC_W'(lut_seg), ACC_W'(n - 1));
        chk({tag, "_idx"}, ACC_W'(lut_idx), ACC_W'(up[(n-1)*IDX_BITS +: IDX_BITS]));
      end
      step();
      n++;
    end
    chk({tag, "_latency"}, ACC_W'(n), ACC_W'(10));
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_hs_ready"}, ACC_W'(in_ready), ACC_W'(1));
    chk({tag, "_hs_valid"}, ACC_W'(out_valid), ACC_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] emax;
    int               n;
    int               last_cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_lower  = '0;
    in_upper  = '0;
    mode      = 2'd0;
    repeat (2) step();
    chk("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
    chk("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_lut_seg", ACC_W'(lut_seg), '0);
    chk("rst_lut_idx", ACC_W'(lut_idx), '0);
    rst_n = 1'b1;
    step();

    // Zero upper word: result is just the lower word.
    run_op('0, WIDTH'('h1234), ACC_W'('h1234), 1'b1, "zero");
    handshake("zero");

    // Ordering stub, then backpressure with in_valid held high.
    mode = 2'd1;
    run_op(UpAllMax, '0, ACC_W'(1144), 1'b1, "order");
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", out_data, ACC_W'(1144));
      chk("bp_in_ready", ACC_W'(in_ready), ACC_W'(0));
      chk("bp_out_valid", ACC_W'(out_valid), ACC_W'(1));
      step();
    end
    chk("bp_data6", out_data, ACC_W'(1144));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_hs_ready", ACC_W'(in_ready), ACC_W'(1));
    chk("bp_hs_valid", ACC_W'(out_valid), ACC_W'(0));
    step();

    // Maximum carry: 9 * (2^1024 - 1).
    mode = 2'd2;
    emax = {4'h8, {(WIDTH-4){1'b1}}, 4'h7};
    run_op(UpAllMax, {WIDTH{1'b1}}, emax, 1'b0, "maxcarry");
    chk("maxcarry_top", ACC_W'(out_data[ACC_W-1:WIDTH]), ACC_W'(8));
    handshake("maxcarry");

    // Back-to-back: three operands with in_valid and out_ready held high.
    mode      = 2'd1;
    in_upper  = UpAllOne;
    in_lower  = WIDTH'(100);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    last_cyc  = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      step();
      while (!out_valid && n < 30) begin
        step();
        n++;
      end
      case (i)
        0: begin
          chk("b2b_data0", out_data, ACC_W'(1004));
          in_upper = UpRamp;
          in_lower = WIDTH'(16);
        end
        1: begin
          chk("b2b_data1", out_data, ACC_W'(940));
          chk("b2b_gap1", ACC_W'(cyc - last_cyc), ACC_W'(11));
          in_upper = '0;
          in_lower = WIDTH'(5);
        end
        default: begin
          chk("b2b_data2", out_data, ACC_W'(901));
          chk("b2b_gap2", ACC_W'(cyc - last_cyc), ACC_W'(11));
          in_valid = 1'b0;
        end
      endcase
      chk("b2b_valid", ACC_W'(out_valid), ACC_W'(1));
      last_cyc = cyc;
    end
    step();
    out_ready = 1'b0;
    chk("b2b_idle_ready", ACC_W'(in_ready), ACC_W'(1));
    chk("b2b_idle_valid", ACC_W'(out_valid), ACC_W'(0));

    // Reset in the middle of ISSUE, then a fresh operand.
    in_upper = UpAllOne;
    in_lower = WIDTH'(100);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("rst_mid_seg", ACC_W'(lut_seg), ACC_W'(3));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", ACC_W'(in_ready), ACC_W'(1));
    chk("rst_mid_valid", ACC_W'(out_valid), ACC_W'(0));
    chk("rst_mid_idx", ACC_W'(lut_idx), '0);
    chk("rst_mid_data", out_data, '0);
    step();
    rst_n = 1'b1;
    step();
    run_op(UpRamp, WIDTH'(16), ACC_W'(940), 1'b1, "fresh");
    handshake("fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
